// File: rtl/fpna_cfg_loader.sv
// Serial configuration loader: shifts a bitstream in, validates length (and CRC-8 when
// CFG_CRC_EN is defined), then atomically commits the payload to the fabric shadow register.
module fpna_cfg_loader #(
  parameter int CFG_BITS = 64,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                config_en,
  input  logic                bs_in,
  output logic                bs_out,
  output logic [CFG_BITS-1:0] cfg_out,
  output logic                cfg_valid,
  output logic                cfg_error,
  output logic                busy
);

`ifdef CFG_CRC_EN
  localparam int SR_W = CFG_BITS + 8;
`else
  localparam int SR_W = CFG_BITS;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SR_W);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, COMMIT} state_t;

  state_t              state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CFG_BITS-1:0] cfg_out_q, cfg_out_d;
  logic                cfg_valid_q, cfg_valid_d;
  logic                cfg_error_q, cfg_error_d;
  logic                shift_en;
  logic                crc_ok;

`ifdef CFG_CRC_EN
  logic [7:0] crc_q, crc_d;

  // Serial CRC-8, polynomial x^8+x^2+x+1, MSB first.
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    crc_step = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (config_en && state_q == IDLE)
      crc_d = crc_step(8'h00, bs_in);
    else if (config_en && state_q == SHIFT)
      crc_d = crc_step(crc_q, bs_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= 8'h00;
    else        crc_q <= crc_d;
  end

  assign crc_ok = (crc_q == 8'h00);
`else
  assign crc_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    cfg_out_d   = cfg_out_q;
    cfg_valid_d = cfg_valid_q;
    cfg_error_d = cfg_error_q;
    shift_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (config_en) begin
          state_d     = SHIFT;
          shift_en    = 1'b1;
          cnt_d       = CNT_W'(1);
          cfg_error_d = 1'b0;
        end
      end
      SHIFT: begin
        if (config_en) begin
          shift_en = 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        // Outputs are written on the CHECK->COMMIT edge so the fabric sees them one cycle
        // after config_en falls; COMMIT only holds busy for the remaining cycle.
        if (cnt_q == CNT_FULL && crc_ok) begin
          state_d     = COMMIT;
          cfg_out_d   = sr_q[SR_W-1 -: CFG_BITS];
          cfg_valid_d = 1'b1;
        end else begin
          state_d     = IDLE;
          cfg_error_d = 1'b1;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (shift_en) sr_d = {sr_q[SR_W-2:0], bs_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      cfg_out_q   <= '0;
      cfg_valid_q <= 1'b0;
      cfg_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      cfg_out_q   <= cfg_out_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_error_q <= cfg_error_d;
    end
  end

  assign bs_out    = sr_q[SR_W-1];
  assign cfg_out   = cfg_out_q;
  assign cfg_valid = cfg_valid_q;
  assign cfg_error = cfg_error_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fpna_cfg_loader.sv
// Directed bench for fpna_cfg_loader (CFG_BITS=16); CRC checks run when CFG_CRC_EN is defined.
module tb_fpna_cfg_loader;
  localparam int CFG_BITS = 16;
`ifdef CFG_CRC_EN
  localparam int SR_W = 24;
`else
  localparam int SR_W = 16;
`endif

  logic                clk;
  logic                rst_n;
  logic                config_en;
  logic                bs_in;
  logic                bs_out;
  logic [CFG_BITS-1:0] cfg_out;
  logic                cfg_valid;
  logic                cfg_error;
  logic                busy;

  int checks   = 0;
  int failures = 0;

  fpna_cfg_loader #(.CFG_BITS(CFG_BITS), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .config_en (config_en),
    .bs_in     (bs_in),
    .bs_out    (bs_out),
    .cfg_out   (cfg_out),
    .cfg_valid (cfg_valid),
    .cfg_error (cfg_error),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] payload;
    int          delta;
    logic        exp_valid;
    logic        exp_error;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [15:0] p);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 15; i >= 0; i--)
      c = {c[6:0], 1'b0} ^ ((c[7] ^ p[i]) ? 8'h07 : 8'h00);
    return c;
  endfunction

  function automatic logic [63:0] full_stream(input logic [15:0] p);
`ifdef CFG_CRC_EN
    return {40'd0, p, crc8(p)};
`else
    return {48'd0, p};
`endif
  endfunction

  // Called at a negedge; drives bits s[n-1]..s[0], one per clock, returns at a negedge.
  task automatic shift_stream(input logic [63:0] s, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      config_en = 1'b1;
      bs_in     = s[i];
      @(negedge clk);
    end
  endtask

  task automatic finish_load(input string tag, input logic ev, input logic ee,
                             input logic [15:0] eo);
    config_en = 1'b0;
    bs_in     = 1'b0;
    @(negedge clk);
    check({tag, " busy_in_check"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, " cfg_out"},   32'(cfg_out),   32'(eo));
    check({tag, " cfg_valid"}, 32'(cfg_valid), 32'(ev));
    check({tag, " cfg_error"}, 32'(cfg_error), 32'(ee));
    check({tag, " busy_after_decide"}, 32'(busy), ee ? 32'd0 : 32'd1);
    @(negedge clk);
    check({tag, " busy_idle"}, 32'(busy), 32'd0);
    $display("load %s: cfg_out=%h valid=%b error=%b", tag, cfg_out, cfg_valid, cfg_error);
  endtask

  initial begin
    logic [63:0] s;
    logic [15:0] cap;
    int          n;

    vecs[0] = '{16'hA5C3,  0, 1'b1, 1'b0, 16'hA5C3};
    vecs[1] = '{16'hA5C3, -1, 1'b1, 1'b1, 16'hA5C3};
    vecs[2] = '{16'h1234,  1, 1'b1, 1'b1, 16'hA5C3};
    vecs[3] = '{16'h3C96,  0, 1'b1, 1'b0, 16'h3C96};
    vecs[4] = '{16'hFFFF, -1, 1'b1, 1'b1, 16'h3C96};
    vecs[5] = '{16'h0F0F,  1, 1'b1, 1'b1, 16'h3C96};

    rst_n     = 1'b0;
    config_en = 1'b0;
    bs_in     = 1'b0;
    repeat (2) @(negedge clk);
    check("reset cfg_out",   32'(cfg_out),   32'd0);
    check("reset cfg_valid", 32'(cfg_valid), 32'd0);
    check("reset cfg_error", 32'(cfg_error), 32'd0);
    check("reset busy",      32'(busy),      32'd0);
    check("reset bs_out",    32'(bs_out),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      s = full_stream(vecs[v].payload);
      n = SR_W;
      if (vecs[v].delta < 0) begin
        s = s >> 1;
        n = SR_W - 1;
      end else if (vecs[v].delta > 0) begin
        s = s << 1;
        n = SR_W + 1;
      end
      shift_stream(s, n);
      finish_load($sformatf("vec%0d", v), vecs[v].exp_valid, vecs[v].exp_error,
                  vecs[v].exp_out);
    end

    // Daisy-chain: the first 16 stream bits reappear on bs_out after SR_W enabled cycles.
    s   = full_stream(16'hA5C3) << 16;
    n   = SR_W + 16;
    cap = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (n - 1 - i >= SR_W) cap = {cap[14:0], bs_out};
      config_en = 1'b1;
      bs_in     = s[i];
      @(negedge clk);
    end
    check("burst bs_out stream", 32'(cap), 32'h0000A5C3);
    finish_load("burst", 1'b1, 1'b1, 16'h3C96);

    // config_en raised during CHECK/COMMIT must not shift or count.
    shift_stream(full_stream(16'hA5C3), SR_W);
    config_en = 1'b0;
    @(negedge clk);
    check("reassert busy_in_check", 32'(busy), 32'd1);
    config_en = 1'b1;
    bs_in     = 1'b1;
    @(negedge clk);
    check("reassert commit cfg_out", 32'(cfg_out), 32'h0000A5C3);
    check("reassert busy_in_commit", 32'(busy), 32'd1);
    @(negedge clk);
    check("reassert busy_idle", 32'(busy), 32'd0);
    shift_stream(full_stream(16'h5AA5), SR_W);
    finish_load("reassert_reload", 1'b1, 1'b0, 16'h5AA5);

    // Asynchronous reset in the middle of a load.
    shift_stream(full_stream(16'hC001) >> (SR_W - 8), 8);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst cfg_out",   32'(cfg_out),   32'd0);
    check("async_rst cfg_valid", 32'(cfg_valid), 32'd0);
    check("async_rst busy",      32'(busy),      32'd0);
    check("async_rst bs_out",    32'(bs_out),    32'd0);
    config_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    shift_stream(full_stream(16'h1234), SR_W);
    finish_load("after_reset", 1'b1, 1'b0, 16'h1234);

`ifdef CFG_CRC_EN
    shift_stream({40'd0, 16'h0001, 8'h07}, SR_W);
    finish_load("crc_good", 1'b1, 1'b0, 16'h0001);
    shift_stream({40'd0, 16'h0001, 8'h06}, SR_W);
    finish_load("crc_bad", 1'b1, 1'b1, 16'h0001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
